// File: rtl/uart_tx_fifo_pkg.sv
// Shared types, parity codes and frame-length helper for the UART transmitter.
// Optional break generation is enabled by defining UART_TX_BREAK_EN.
package uart_pkg;

`ifdef UART_TX_BREAK_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    BREAK = 2'd3
  } uart_tx_state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } uart_tx_state_t;
`endif

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  // Total bits on the line for one frame: start + data + parity + stop.
  function automatic int unsigned frame_bits(input int unsigned data_w,
                                             input int unsigned parity,
                                             input int unsigned stop_bits);
    return 32'd1 + data_w + ((parity != PAR_NONE) ? 32'd1 : 32'd0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Host-side bus of the UART transmitter: push handshake, line and status.
// send_brk exists only when UART_TX_BREAK_EN is defined.
interface uart_tx_fifo_if #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic              trmt;
  logic [DATA_W-1:0] tx_data;
  logic              tx_rdy;
  logic              TX;
  logic              busy;
  logic              tx_done;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              ovf;

`ifdef UART_TX_BREAK_EN
  logic              send_brk;

  modport master (output trmt, tx_data, send_brk,
                  input  tx_rdy, TX, busy, tx_done, fifo_cnt, ovf);
  modport slave  (input  trmt, tx_data, send_brk,
                  output tx_rdy, TX, busy, tx_done, fifo_cnt, ovf);
`else
  modport master (output trmt, tx_data,
                  input  tx_rdy, TX, busy, tx_done, fifo_cnt, ovf);
  modport slave  (input  trmt, tx_data,
                  output tx_rdy, TX, busy, tx_done, fifo_cnt, ovf);
`endif

endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Synchronous FIFO with registered pointers, count and flags.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Next occupancy; simultaneous push and pop cancel out.
  always_comb begin
    cnt_nxt = cnt;
    case ({do_push, do_pop})
      2'b10:   cnt_nxt = cnt + CW'(1);
      2'b01:   cnt_nxt = cnt - CW'(1);
      default: cnt_nxt = cnt;
    endcase
  end

  // Pointers, count and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt   <= cnt_nxt;
      full  <= (cnt_nxt == CW'(DEPTH));
      empty <= (cnt_nxt == '0);
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter with a small transmit FIFO.
// Defining UART_TX_BREAK_EN adds a break generator driven by send_brk.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 2604,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_fifo_if.slave bus
);

  localparam int unsigned FRAME_BITS = frame_bits(DATA_W, PARITY, STOP_BITS);
  localparam int unsigned BAUD_W     = $clog2(CLK_DIV);
`ifdef UART_TX_BREAK_EN
  localparam int unsigned BIT_MAX    = 2 * FRAME_BITS;
`else
  localparam int unsigned BIT_MAX    = FRAME_BITS;
`endif
  localparam int unsigned BIT_W      = $clog2(BIT_MAX + 1);
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1;

  uart_tx_state_t        state, state_nxt;
  logic [BAUD_W-1:0]     baud_cnt, baud_nxt;
  logic [BIT_W-1:0]      bit_cnt, bit_nxt;
  logic [FRAME_BITS-1:0] shreg, shreg_nxt;
  logic [FRAME_BITS-1:0] frame;
  logic                  tx_q, tx_nxt;
  logic                  busy_q;
  logic                  done_q, done_set;
  logic                  ovf_q;
  logic                  baud_tc;
  logic                  more_data;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0]     fifo_dout;
  logic [CNT_W-1:0]      fifo_cnt;

  assign fifo_push = bus.trmt & ~fifo_full;
  // A word arriving this cycle is visible to the FSM so LOAD follows the push directly.
  assign more_data = ~fifo_empty | fifo_push;
  assign baud_tc   = (baud_cnt == BAUD_W'(CLK_DIV - 1));

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (bus.tx_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .cnt   (fifo_cnt)
  );

  // Assemble the line image of the head word, bit 0 goes out first.
  always_comb begin
    frame           = '1;
    frame[0]        = 1'b0;
    frame[DATA_W:1] = fifo_dout;
    if (PARITY == PAR_EVEN)     frame[DATA_W+1] = ^fifo_dout;
    else if (PARITY == PAR_ODD) frame[DATA_W+1] = ~^fifo_dout;
  end

  // Next-state, counters and shifter.
  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;
    fifo_pop  = 1'b0;
    done_set  = 1'b0;
    tx_nxt    = 1'b1;
    case (state)
      IDLE: begin
        if (more_data) state_nxt = LOAD;
`ifdef UART_TX_BREAK_EN
        if (bus.send_brk) begin
          state_nxt = BREAK;
          baud_nxt  = '0;
          bit_nxt   = '0;
        end
`endif
      end
      LOAD: begin
        fifo_pop  = 1'b1;
        shreg_nxt = frame;
        baud_nxt  = '0;
        bit_nxt   = '0;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        if (baud_tc) begin
          baud_nxt  = '0;
          shreg_nxt = {1'b1, shreg[FRAME_BITS-1:1]};
          if (bit_cnt == BIT_W'(FRAME_BITS - 1)) begin
            bit_nxt = '0;
            if (more_data) begin
              state_nxt = LOAD;
            end else begin
              state_nxt = IDLE;
              done_set  = 1'b1;
            end
          end else begin
            bit_nxt = bit_cnt + BIT_W'(1);
          end
        end else begin
          baud_nxt = baud_cnt + BAUD_W'(1);
        end
      end
`ifdef UART_TX_BREAK_EN
      BREAK: begin
        if (baud_tc) begin
          baud_nxt = '0;
          if (bit_cnt != BIT_W'(BIT_MAX)) bit_nxt = bit_cnt + BIT_W'(1);
        end else begin
          baud_nxt = baud_cnt + BAUD_W'(1);
        end
        // Leave once the minimum break length completes and the request is gone.
        if (!bus.send_brk &&
            ((bit_cnt == BIT_W'(BIT_MAX)) ||
             (baud_tc && (bit_cnt == BIT_W'(BIT_MAX - 1))))) begin
          state_nxt = IDLE;
          baud_nxt  = '0;
          bit_nxt   = '0;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase

    if (state_nxt == SHIFT) tx_nxt = shreg_nxt[0];
`ifdef UART_TX_BREAK_EN
    else if (state_nxt == BREAK) tx_nxt = 1'b0;
`endif
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      shreg    <= shreg_nxt;
      tx_q     <= tx_nxt;
      busy_q   <= (state_nxt != IDLE);
      if (state_nxt == LOAD) done_q <= 1'b0;
      else if (done_set)     done_q <= 1'b1;
      ovf_q    <= ovf_q | (bus.trmt & fifo_full);
    end
  end

  assign bus.TX       = tx_q;
  assign bus.busy     = busy_q;
  assign bus.tx_done  = done_q;
  assign bus.ovf      = ovf_q;
  assign bus.tx_rdy   = ~fifo_full;
  assign bus.fifo_cnt = fifo_cnt;

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Parametrised successor to the team's fixed 8N1 UART transmitter.
- Adds configurable baud divisor, data width, parity mode, stop-bit count and a small transmit FIFO, so the host can queue bytes back-to-back without waiting on tx_done.
- Sits between the segway telemetry/command logic and the serial TX pin.

Parameters:
- CLK_DIV, 2604: clk cycles per bit (2604 gives 19200 baud at 50 MHz); legal range 2 to 65535.
- DATA_W, 8: data bits per frame; legal range 5 to 9.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: number of stop bits; legal values 1 or 2.
- FIFO_DEPTH, 4: queued frames; must be a power of 2, range 2 to 16.

Ports:
- clk  in  1  system clock; everything is posedge.
- rst  in  1  asynchronous reset, active-high.
- trmt  in  1  push request; tx_data is accepted when trmt=1 and tx_rdy=1.
- tx_data  in  DATA_W  frame payload, sent LSB first.
- tx_rdy  out  1  FIFO not full.
- TX  out  1  serial line; idle level is 1.
- busy  out  1  a frame is in progress (state is not IDLE).
- tx_done  out  1  sticky: all queued data has been sent.
- fifo_cnt  out  $clog2(FIFO_DEPTH)+1  number of occupied FIFO entries.
- ovf  out  1  sticky: a push was attempted while the FIFO was full.

Behaviour:
- Reset values (asynchronous, immediate): TX=1, busy=0, tx_done=0, tx_rdy=1, fifo_cnt=0, ovf=0, state=IDLE. Baud counter, bit counter and shift register are cleared.
- Reset mid-frame aborts the frame, drives TX=1 immediately and discards the FIFO contents.
- FIFO is synchronous with registered pointers:
  - Push when trmt & tx_rdy.
  - Pop when the FSM loads a frame.
  - Push and pop in the same cycle leave fifo_cnt unchanged.
  - Push while full is dropped and sets ovf; ovf clears only on rst.
- Frame layout: start bit (0), DATA_W data bits LSB first, optional parity bit, STOP_BITS stop bits (1). FRAME_BITS = 1 + DATA_W + (PARITY!=0) + STOP_BITS.
- Parity is computed on the popped word at load. Even: parity bit = ^data. Odd: parity bit = ~^data.
- FSM states: IDLE, LOAD, SHIFT.
  - IDLE -> LOAD when fifo_cnt != 0.
  - LOAD (exactly 1 cycle): pop the FIFO, fill the shift register with the full frame, clear baud_cnt and bit_cnt, clear tx_done. -> SHIFT.
  - SHIFT: TX = shreg[0]. baud_cnt counts 0 to CLK_DIV-1. At terminal count: shift in a 1, bit_cnt+1, baud_cnt returns to 0.
  - SHIFT, when the terminal count occurs with bit_cnt == FRAME_BITS-1:
    - If fifo_cnt != 0, go to LOAD (back-to-back).
    - Otherwise go to IDLE and set tx_done.
- Timing:
  - A push into an empty FIFO in cycle N makes fifo_cnt nonzero in N+1. LOAD occurs in N+1 and the start bit appears on TX in N+2.
  - Each bit is held exactly CLK_DIV cycles.
  - Back-to-back frames have exactly 1 LOAD cycle of extra stop level between them.
- busy = 1 in LOAD and SHIFT.
- tx_done stays 0 while the FIFO holds data.
- baud_cnt width is $clog2(CLK_DIV); it never counts past CLK_DIV-1 (wrap to 0).

Optional Feature:
- Macro: UART_TX_BREAK_EN.
- When defined:
  - Adds input port send_brk (1 bit).
  - In IDLE, send_brk=1 enters state BREAK. TX is held 0 for as long as send_brk is asserted, with a minimum of 2×FRAME_BITS×CLK_DIV cycles; the counter is reused.
  - BREAK then returns to IDLE.
  - While in BREAK: busy=1 and the FIFO is not popped.
  - send_brk is ignored outside IDLE.
- When undefined: no port, no BREAK state, and logic is identical to the base behaviour.

Decomposition:
- Package uart_pkg holds:
  - the state enum typedef uart_tx_state_t (IDLE, LOAD, SHIFT, BREAK);
  - parity-mode localparams PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2;
  - function frame_bits(DATA_W, PARITY, STOP_BITS).
- One sub-module: sync_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, full, empty, cnt). It is reusable by the future UART_rx.

Test Plan (bench uses CLK_DIV=16 unless noted):
- 8N1: push 0xA5 into an idle block. TX shows 0,1,0,1,0,0,1,0,1,1, each held 16 cycles. The start bit begins 2 cycles after the push. tx_done rises at the end of the stop bit.
- Even parity, DATA_W=7: push 0x03 -> parity bit 0. Odd parity -> parity bit 1. Frame is 10 bits.
- STOP_BITS=2, back-to-back: push 0x55 then 0x0F on consecutive cycles.
  - fifo_cnt reaches 1 after the first LOAD.
  - Second start bit follows 2×16+1 cycles of TX=1.
  - busy stays 1 throughout.
  - tx_done is 0 until the second frame ends.
- Overflow, FIFO_DEPTH=4: push 6 words with no gap.
  - tx_rdy drops when the FIFO is full.
  - ovf=1.
  - Exactly 5 frames are transmitted: the one loaded, then 4 queued.
- Reset mid-frame: assert rst during data bit 3 -> TX=1 in the same cycle, fifo_cnt=0, busy=0. After release, no frame is sent.
- With UART_TX_BREAK_EN, 8N1, CLK_DIV=16: pulse send_brk for 1 cycle -> TX=0 for exactly 320 cycles, then back to IDLE.
